multisim_stream_fifo: RTL and testbench
=======================================

Name: multisim_stream_fifo

Overview:
- Elastic buffer between a `multisim_server_pull` instance (producer) and a `multisim_server_push` instance (consumer) in emulation tops.
- Decouples the pull server's DPI polling cadence from the push server's `data_rdy` backpressure, so no received word is lost while the push side is stalled.
- Exposes occupancy and wrap-around transfer counters for debug and exit checks.

Parameters:
- DATA_WIDTH, 64, payload width in bits; must be ≥1.
- DEPTH, 8, number of entries; power of two, ≥2.
- CNT_WIDTH, 32, width of the transfer counters.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_vld  input  1  producer word valid (driven by the pull server's `data_vld`).
- in_data  input  DATA_WIDTH  producer word.
- in_rdy  output  1  FIFO can accept a word (drives the pull server's `data_rdy`).
- out_vld  output  1  head word valid (drives the push server's `data_vld`).
- out_data  output  DATA_WIDTH  head word.
- out_rdy  input  1  consumer accepts the head word (from the push server's `data_rdy`).
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- in_cnt  output  CNT_WIDTH  accepted-word count; wraps modulo 2^CNT_WIDTH.
- out_cnt  output  CNT_WIDTH  delivered-word count; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset: asynchronous assert on rst_n low; state leaves reset on the first clk edge after rst_n goes high.
  - Reset values: wr_ptr = 0, rd_ptr = 0, level = 0, in_cnt = 0, out_cnt = 0, out_vld = 0, in_rdy = 1, out_data = 0.
- Pointers are $clog2(DEPTH)+1 bits (extra wrap bit).
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal, wrap bits differ).
- Write: when in_vld && in_rdy at a posedge, store in_data at mem[wr_ptr low bits], then wr_ptr++ and in_cnt++.
- Read: when out_vld && out_rdy at a posedge, rd_ptr++ and out_cnt++.
- Output signals:
  - in_rdy = !full. It is purely state-derived, with no combinational path from out_rdy.
  - out_vld = !empty.
  - out_data = mem[rd_ptr low bits]. It is combinational from registers and stable while out_vld && !out_rdy.
- Latency: a word written at edge N is presented with out_vld = 1 after edge N. There is no fall-through within the same cycle; minimum latency is 1 cycle.
- Throughput: one push and one pop per cycle sustained when neither full nor empty.
- Simultaneous push and pop in the same cycle:
  - level is unchanged.
  - Both pointers advance.
  - Both counters increment.
- Full: in_rdy = 0. A simultaneous pop does not allow a same-cycle push; the slot frees on the next cycle.
- Empty: out_vld = 0. out_rdy is ignored and no counter changes.
- level = wr_ptr − rd_ptr, computed modulo 2^($clog2(DEPTH)+1).
- Pointer wrap-around: correct across ≥ 2·DEPTH consecutive writes.
- Counter wrap: in_cnt and out_cnt roll over 2^CNT_WIDTH−1 → 0 silently.
- Protocol rule: in_vld asserted while in_rdy = 0 is legal. The word is not taken, and the producer must hold it.
- Reset mid-operation: contents are discarded and all outputs return to their reset values immediately, independent of clk.

Decomposition:
- Package multisim_stream_pkg:
  - default CNT_WIDTH constant;
  - typedef cnt_t (logic [CNT_WIDTH-1:0]);
  - function ptr_width(depth), returning $clog2(depth)+1.
- Sub-module multisim_stream_fifo_mem:
  - DEPTH×DATA_WIDTH register array;
  - one synchronous write port and one asynchronous read port;
  - no reset on the storage.
- Control, pointers and counters live in the top module.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then high → in_rdy = 1, out_vld = 0, level = 0, in_cnt = 0, out_cnt = 0.
- Streaming, DEPTH = 8, out_rdy held at 1: write 0x1..0x20 back-to-back → out_data sequence 0x1..0x20, each word one cycle after its write, level ≤ 1, in_cnt = out_cnt = 32.
- Fill to full, out_rdy = 0: write 10 words with in_vld held → exactly 8 accepted, in_rdy = 0 from the cycle after the 8th write, level = 8. Release out_rdy → words drain in order, and words 9 and 10 are accepted after the first pop.
- Random stall on both sides: random in_vld/out_rdy at 50% for 2000 cycles → scoreboard order matches, no loss or duplication, level never > 8, data held stable during stalls.
- Counter wrap: preload by forcing CNT_WIDTH = 4 and transfer 20 words → in_cnt = 4 (20 mod 16).
- Reset mid-operation: level = 5, assert rst_n asynchronously between edges → out_vld = 0, level = 0 immediately; after release, the first new word written emerges first.

Source files
------------

// File: rtl/multisim_stream_pkg.sv
// Shared constants and helpers for the multisim stream FIFO.
// Pointer width carries one extra wrap bit beyond the address.
package multisim_stream_pkg;

    localparam int CNT_WIDTH_DEF = 32;

    typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/multisim_stream_fifo_mem.sv
// FIFO storage: one synchronous write port, one async read port.
// Storage is deliberately left unreset; validity comes from pointers.
module multisim_stream_fifo_mem
    import multisim_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Capture the producer word on an accepted push
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/multisim_stream_fifo.sv
// Elastic buffer between the pull server and the push server.
// Holds words while the push side stalls; exposes debug counters.
module multisim_stream_fifo
    import multisim_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_vld,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_rdy,
    output logic                   out_vld,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic                   out_rdy,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_WIDTH-1:0]   in_cnt,
    output logic [CNT_WIDTH-1:0]   out_cnt
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] rdata;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                && (wr_ptr[AW] != rd_ptr[AW]);

    assign in_rdy  = !full;
    assign out_vld = !empty;
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    assign level = wr_ptr - rd_ptr;

    // Head word is forced to zero while empty so idle output is defined
    assign out_data = empty ? '0 : rdata;

    // Advance pointers and transfer counters on accepted handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                in_cnt <= in_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                out_cnt <= out_cnt + 1'b1;
            end
        end
    end

    multisim_stream_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_multisim_stream_fifo.sv
// Directed and scoreboarded bench for multisim_stream_fifo.
// A second small instance covers counter wrap.
module tb_multisim_stream_fifo;

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic [63:0] in_data;
    logic        in_rdy;
    logic        out_vld;
    logic [63:0] out_data;
    logic        out_rdy;
    logic [3:0]  level;
    logic [31:0] in_cnt;
    logic [31:0] out_cnt;

    logic        in_vld4;
    logic [7:0]  in_data4;
    logic        in_rdy4;
    logic        out_vld4;
    logic [7:0]  out_data4;
    logic        out_rdy4;
    logic [2:0]  level4;
    logic [3:0]  in_cnt4;
    logic [3:0]  out_cnt4;

    int n_chk;
    int n_fail;

    multisim_stream_fifo #(
        .DATA_WIDTH (64),
        .DEPTH      (8),
        .CNT_WIDTH  (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .level    (level),
        .in_cnt   (in_cnt),
        .out_cnt  (out_cnt)
    );

    multisim_stream_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (4),
        .CNT_WIDTH  (4)
    ) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld4),
        .in_data  (in_data4),
        .in_rdy   (in_rdy4),
        .out_vld  (out_vld4),
        .out_data (out_data4),
        .out_rdy  (out_rdy4),
        .level    (level4),
        .in_cnt   (in_cnt4),
        .out_cnt  (out_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [63:0] data;
        logic        rdy;
        logic        e_in_rdy;
        logic        e_out_vld;
        logic [63:0] e_out_data;
        logic [3:0]  e_level;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_vld   = 1'b0;
        out_rdy  = 1'b0;
        in_vld4  = 1'b0;
        out_rdy4 = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".in_rdy"}, 64'(in_rdy), 64'd1);
        chk({nm, ".out_vld"}, 64'(out_vld), 64'd0);
        chk({nm, ".level"}, 64'(level), 64'd0);
        chk({nm, ".in_cnt"}, 64'(in_cnt), 64'd0);
        chk({nm, ".out_cnt"}, 64'(out_cnt), 64'd0);
        chk({nm, ".out_data"}, out_data, 64'd0);
    endtask

    initial begin
        logic [63:0] q[$];
        logic [63:0] pend;
        logic        pvld;
        int          w;
        int          e;

        n_chk    = 0;
        n_fail   = 0;
        in_data  = '0;
        in_data4 = '0;

        // Reset then idle
        in_vld   = 1'b0;
        out_rdy  = 1'b0;
        in_vld4  = 1'b0;
        out_rdy4 = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_idle("rst_asserted");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk_idle("post_reset");

        // Table-driven handshake vectors
        tv[0] = '{1, 64'hA1, 0, 1, 1, 64'hA1, 1};
        tv[1] = '{1, 64'hA2, 0, 1, 1, 64'hA1, 2};
        tv[2] = '{0, 64'h00, 1, 1, 1, 64'hA2, 1};
        tv[3] = '{1, 64'hA3, 1, 1, 1, 64'hA3, 1};
        tv[4] = '{0, 64'h00, 1, 1, 0, 64'h00, 0};
        tv[5] = '{0, 64'h00, 1, 1, 0, 64'h00, 0};
        tv[6] = '{1, 64'hA4, 1, 1, 1, 64'hA4, 1};
        tv[7] = '{0, 64'h00, 0, 1, 1, 64'hA4, 1};
        tv[8] = '{0, 64'h00, 1, 1, 0, 64'h00, 0};
        for (int i = 0; i < 9; i++) begin
            in_vld  = tv[i].vld;
            in_data = tv[i].data;
            out_rdy = tv[i].rdy;
            step();
            chk($sformatf("tv%0d.in_rdy", i), 64'(in_rdy),
                64'(tv[i].e_in_rdy));
            chk($sformatf("tv%0d.out_vld", i), 64'(out_vld),
                64'(tv[i].e_out_vld));
            chk($sformatf("tv%0d.out_data", i), out_data,
                tv[i].e_out_data);
            chk($sformatf("tv%0d.level", i), 64'(level),
                64'(tv[i].e_level));
        end
        chk("tv.in_cnt", 64'(in_cnt), 64'd4);
        chk("tv.out_cnt", 64'(out_cnt), 64'd4);

        // Streaming with consumer always ready
        do_reset();
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            in_data = 64'(k);
            step();
            chk($sformatf("stream%0d.out_data", k), out_data, 64'(k));
            chk($sformatf("stream%0d.level", k), 64'(level), 64'd1);
        end
        in_vld = 1'b0;
        step();
        chk("stream.level_end", 64'(level), 64'd0);
        chk("stream.in_cnt", 64'(in_cnt), 64'd32);
        chk("stream.out_cnt", 64'(out_cnt), 64'd32);

        // Fill to full with consumer stalled
        do_reset();
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        w = 1;
        for (int c = 0; c < 10; c++) begin
            in_data = 64'(w);
            #1;
            chk($sformatf("fill%0d.in_rdy", c), 64'(in_rdy),
                64'(c < 8));
            step();
            if (c < 8) w++;
        end
        chk("fill.level", 64'(level), 64'd8);
        chk("fill.in_cnt", 64'(in_cnt), 64'd8);
        chk("fill.in_rdy", 64'(in_rdy), 64'd0);
        chk("fill.head", out_data, 64'd1);
        in_data = 64'd9;
        out_rdy = 1'b1;
        step();
        chk("pop1.in_cnt", 64'(in_cnt), 64'd8);
        chk("pop1.level", 64'(level), 64'd7);
        chk("pop1.in_rdy", 64'(in_rdy), 64'd1);
        chk("pop1.out_data", out_data, 64'd2);
        step();
        chk("pop2.in_cnt", 64'(in_cnt), 64'd9);
        chk("pop2.level", 64'(level), 64'd7);
        chk("pop2.out_data", out_data, 64'd3);
        in_data = 64'd10;
        step();
        chk("pop3.in_cnt", 64'(in_cnt), 64'd10);
        chk("pop3.out_data", out_data, 64'd4);
        in_vld = 1'b0;
        for (e = 4; e <= 10; e++) begin
            chk($sformatf("drain%0d.out_data", e), out_data, 64'(e));
            step();
        end
        chk("drain.out_vld", 64'(out_vld), 64'd0);
        chk("drain.out_cnt", 64'(out_cnt), 64'd10);

        // Random stalls against a queue scoreboard
        do_reset();
        q.delete();
        pvld = 1'b0;
        pend = '0;
        for (int c = 0; c < 2000; c++) begin
            #1;
            chk("rnd.out_vld", 64'(out_vld), 64'(q.size() != 0));
            chk("rnd.in_rdy", 64'(in_rdy), 64'(q.size() < 8));
            chk("rnd.level", 64'(level), 64'(q.size()));
            if (q.size() != 0) chk("rnd.out_data", out_data, q[0]);
            if (!pvld && $urandom_range(0, 1) == 1) begin
                pvld = 1'b1;
                pend = {$urandom, $urandom};
            end
            in_vld  = pvld;
            in_data = pend;
            out_rdy = 1'($urandom_range(0, 1));
            begin
                logic do_pop;
                logic do_push;
                do_pop  = (q.size() != 0) && out_rdy;
                do_push = pvld && (q.size() < 8);
                step();
                if (do_pop) void'(q.pop_front());
                if (do_push) begin
                    q.push_back(pend);
                    pvld = 1'b0;
                end
            end
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (q.size() != 0) begin
                chk("rnd_drain.out_data", out_data, q[0]);
                void'(q.pop_front());
            end
            step();
        end
        chk("rnd_drain.out_vld", 64'(out_vld), 64'd0);
        chk("rnd_drain.cnt_eq", 64'(in_cnt - out_cnt), 64'd0);

        // Counter wrap on a 4-bit counter instance
        do_reset();
        out_rdy4 = 1'b1;
        in_vld4  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data4 = 8'(k + 8'h30);
            step();
            chk($sformatf("wrap%0d.out_data", k), 64'(out_data4),
                64'(k + 8'h30));
        end
        in_vld4 = 1'b0;
        step();
        chk("wrap.in_cnt", 64'(in_cnt4), 64'd4);
        chk("wrap.out_cnt", 64'(out_cnt4), 64'd4);
        chk("wrap.level", 64'(level4), 64'd0);
        out_rdy4 = 1'b0;

        // Asynchronous reset in the middle of traffic
        do_reset();
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = 64'(k + 64'h50);
            step();
        end
        in_vld = 1'b0;
        chk("mid.level_pre", 64'(level), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.out_vld", 64'(out_vld), 64'd0);
        chk("mid.level", 64'(level), 64'd0);
        chk("mid.in_rdy", 64'(in_rdy), 64'd1);
        chk("mid.in_cnt", 64'(in_cnt), 64'd0);
        chk("mid.out_data", out_data, 64'd0);
        step();
        rst_n   = 1'b1;
        in_vld  = 1'b1;
        in_data = 64'hABC;
        step();
        in_vld = 1'b0;
        chk("mid.new_out_vld", 64'(out_vld), 64'd1);
        chk("mid.new_out_data", out_data, 64'hABC);
        chk("mid.new_level", 64'(level), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
